divide_unit: RTL and testbench

DIVIDE_UNIT -- requirements
Module: divide_unit

---
 rtl/divide_unit.sv | 116 +++++++++++
 tb/tb_divide_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// Iterative 32-bit signed/unsigned divider: one restoring shift-subtract step per cycle,
// 32 busy cycles per divide, results registered on the completion edge.
module divide_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        OP_div,
   input  logic        OP_divu,
   input  logic [31:0] Dividend,
   input  logic [31:0] Divisor,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic        Stall
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StBusy = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [5:0]  count_q, count_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] quotient_q, quotient_d;
   logic [31:0] remainder_q, remainder_d;

   logic [32:0] rem_shift;
   logic [32:0] diff;
   logic        step_ge;
   logic [32:0] step_rem;
   logic [31:0] step_quo;
   logic [31:0] step_rem_lo;
   logic        signed_op;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      // The dividend magnitude shifts out of quo_q from the top as quotient bits shift in below.
      rem_shift   = {rem_q[31:0], quo_q[31]};
      diff        = rem_shift - {1'b0, dvs_q};
      step_ge     = ~diff[32];
      step_rem    = step_ge ? diff : rem_shift;
      step_quo    = {quo_q[30:0], step_ge};
      step_rem_lo = step_rem[31:0];

      signed_op = OP_div;
      a_mag     = (signed_op && Dividend[31]) ? -Dividend : Dividend;
      b_mag     = (signed_op && Divisor[31])  ? -Divisor  : Divisor;

      case (state_q)
         StIdle: begin
            if (OP_div || OP_divu) begin
               state_d   = StBusy;
               count_d   = 6'd32;
               rem_d     = '0;
               quo_d     = a_mag;
               dvs_d     = b_mag;
               // A zero divisor yields all-ones regardless of signs, so never negate it.
               neg_quo_d = signed_op && (Dividend[31] ^ Divisor[31]) && (Divisor != 32'd0);
               neg_rem_d = signed_op && Dividend[31];
            end
         end
         StBusy: begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q - 6'd1;
            if (count_q == 6'd1) begin
               state_d     = StIdle;
               quotient_d  = neg_quo_q ? -step_quo : step_quo;
               remainder_d = neg_rem_q ? -step_rem_lo : step_rem_lo;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign Stall     = (state_q == StBusy);
   assign Quotient  = quotient_q;
   assign Remainder = remainder_q;

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_divide_unit;

   logic        clock;
   logic        reset;
   logic        OP_div;
   logic        OP_divu;
   logic [31:0] Dividend;
   logic [31:0] Divisor;
   logic [31:0] Quotient;
   logic [31:0] Remainder;
   logic        Stall;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q_hold = 32'd0;
   logic [31:0] exp_r_hold = 32'd0;

   divide_unit dut (
      .clock     (clock),
      .reset     (reset),
      .OP_div    (OP_div),
      .OP_divu   (OP_divu),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .Stall     (Stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model straight from the arithmetic definition.
   task automatic model(input logic is_signed, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!is_signed) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endtask

   // Starts a divide; if poke > 0, a conflicting request with new operands is driven at that
   // busy cycle and the operands are then scrambled for the rest of the divide.
   task automatic run_div(input string tag, input logic s, input logic u,
                          input logic [31:0] a, input logic [31:0] b, input int poke);
      logic [31:0] eq, er;
      int cyc;
      model(s, a, b, eq, er);
      @(negedge clock);
      OP_div   = s;
      OP_divu  = u;
      Dividend = a;
      Divisor  = b;
      @(posedge clock);
      #1;
      OP_div  = 1'b0;
      OP_divu = 1'b0;
      check({tag, " stall_set"}, {31'd0, Stall}, 32'd1);
      check({tag, " q_hold"}, Quotient, exp_q_hold);
      cyc = 0;
      while (Stall && cyc < 40) begin
         if (poke > 0 && cyc == poke) begin
            OP_div   = 1'b1;
            Dividend = 32'd50;
            Divisor  = 32'd5;
         end else if (poke > 0 && cyc > poke) begin
            Dividend = $urandom;
            Divisor  = $urandom;
         end
         @(posedge clock);
         #1;
         OP_div = 1'b0;
         cyc++;
         if (Stall && cyc < 32) begin
            if (Quotient !== exp_q_hold || Remainder !== exp_r_hold)
               check({tag, " mid_hold"}, Remainder, exp_r_hold);
         end
      end
      check({tag, " cycles"}, cyc, 32);
      check({tag, " quotient"}, Quotient, eq);
      check({tag, " remainder"}, Remainder, er);
      exp_q_hold = eq;
      exp_r_hold = er;
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      reset    = 1'b0;
      OP_div   = 1'b0;
      OP_divu  = 1'b0;
      Dividend = 32'd0;
      Divisor  = 32'd0;
      #1;
      check("reset stall", {31'd0, Stall}, 32'd0);
      check("reset quotient", Quotient, 32'd0);
      check("reset remainder", Remainder, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      run_div("divu 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 0);
      run_div("div -7/2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
      check("div -7/2 q_lit", Quotient, 32'hFFFF_FFFD);
      run_div("div 7/-2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
      check("div 7/-2 r_lit", Remainder, 32'd1);
      run_div("div min/-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_div("divu max/1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
      run_div("divu 5/0", 1'b0, 1'b1, 32'd5, 32'd0, 0);
      run_div("div -9/0", 1'b1, 1'b0, 32'hFFFF_FFF7, 32'd0, 0);
      run_div("both -100/7", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 0);
      run_div("divu 9/3 poke", 1'b0, 1'b1, 32'd9, 32'd3, 10);

      // Abort mid-divide with reset; outputs must clear without a clock edge.
      @(negedge clock);
      OP_divu  = 1'b1;
      Dividend = 32'd1000;
      Divisor  = 32'd3;
      @(posedge clock);
      #1;
      OP_divu = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("abort stall", {31'd0, Stall}, 32'd0);
      check("abort quotient", Quotient, 32'd0);
      check("abort remainder", Remainder, 32'd0);
      // A start request while reset is held must be ignored.
      OP_divu = 1'b1;
      @(posedge clock);
      #1;
      check("start in reset", {31'd0, Stall}, 32'd0);
      OP_divu = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      exp_q_hold = 32'd0;
      exp_r_hold = 32'd0;
      run_div("divu 20/6", 1'b0, 1'b1, 32'd20, 32'd6, 0);

      for (int i = 0; i < 24; i++) begin
         s = $urandom_range(0, 1);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 300);
            2:       b = -$urandom_range(1, 300);
            default: b = $urandom;
         endcase
         run_div($sformatf("rand%0d", i), s, ~s, a, b, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
